// File: rtl/cfu_xnor_seq_pkg.sv
// -----------------------------------------------------------------------------
// cfu_xnor_seq_pkg
// Shared definitions for the XNOR / XNOR-popcount custom-function unit:
//   - opcode values carried in cmd_payload_function_id[2:0]
//   - controller state encoding
//   - width of the per-command popcount partial sum (holds 0..32)
// -----------------------------------------------------------------------------
package cfu_xnor_seq_pkg;

  localparam logic [2:0] OP_XNOR   = 3'd0;
  localparam logic [2:0] OP_POPACC = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;

  localparam int PSUM_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cfu_xnor_seq_popcnt_slice.sv
// -----------------------------------------------------------------------------
// cfu_popcnt_slice
// Combinational population count of a W-bit vector.
// Ports:
//   i_bits  [W-1:0]   vector to count
//   o_count [CW-1:0]  number of ones, CW = $clog2(W+1)
// -----------------------------------------------------------------------------
module cfu_popcnt_slice #(
  parameter int W = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/cfu_xnor_seq.sv
// -----------------------------------------------------------------------------
// cfu_xnor_seq
// Sequenced custom-function unit: single-cycle XNOR, bit-serial
// XNOR-popcount accumulate, accumulator read and read-and-clear.
// One command in flight; the result is held until the CPU takes it.
//
// Build option: define CFU_XNOR_SEQ_ACC_SAT_EN to make the POPACC
// accumulator add saturate at 2^ACC_WIDTH-1 instead of wrapping.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   cmd_valid / cmd_ready         command handshake
//   cmd_payload_function_id[9:0]  opcode in bits [2:0]
//   cmd_payload_inputs_0/1[31:0]  operands A and B
//   rsp_valid / rsp_ready         response handshake
//   rsp_payload_outputs_0[31:0]   result (acc zero-extended)
//
// state | meaning
// IDLE  | ready for a command
// BUSY  | shifting X through the popcount slice, BITS_PER_CYCLE per cycle
// RESP  | result held, waiting for rsp_ready
// -----------------------------------------------------------------------------
module cfu_xnor_seq
  import cfu_xnor_seq_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4,
  parameter int ACC_WIDTH      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int          SL_W     = $clog2(BITS_PER_CYCLE + 1);
  localparam int          AW1      = ACC_WIDTH + 1;
  localparam logic [4:0]  CNT_INIT = 5'(32 / BITS_PER_CYCLE - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_x;
  logic [PSUM_W-1:0]      r_psum;
  logic [4:0]             r_cnt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [31:0]            r_rsp;

  logic [2:0]             w_op;
  logic [31:0]            w_xnor;
  logic [SL_W-1:0]        w_slice_cnt;
  logic [PSUM_W-1:0]      w_psum_nxt;
  logic [AW1-1:0]         w_acc_sum;
  logic [ACC_WIDTH-1:0]   w_acc_new;
  logic                   w_last;
  logic [6:0]             w_unused_fid;

  assign w_op         = cmd_payload_function_id[2:0];
  assign w_unused_fid = cmd_payload_function_id[9:3];
  assign w_xnor       = ~(cmd_payload_inputs_0 ^ cmd_payload_inputs_1);
  assign w_last       = (r_cnt == 5'd0);

  cfu_popcnt_slice #(.W(BITS_PER_CYCLE)) u_popcnt (
    .i_bits  (r_x[BITS_PER_CYCLE-1:0]),
    .o_count (w_slice_cnt)
  );

  // Partial sum including this cycle's slice; on the last BUSY cycle this
  // is the full popcount that goes into the accumulator.
  assign w_psum_nxt = r_psum + PSUM_W'(w_slice_cnt);
  assign w_acc_sum  = {1'b0, r_acc} + AW1'(w_psum_nxt);

`ifdef CFU_XNOR_SEQ_ACC_SAT_EN
  assign w_acc_new = w_acc_sum[ACC_WIDTH] ? '1 : w_acc_sum[ACC_WIDTH-1:0];
`else
  logic w_unused_carry;
  assign w_unused_carry = w_acc_sum[ACC_WIDTH];
  assign w_acc_new      = w_acc_sum[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Held low during reset so nothing is offered before release.
        cmd_ready = !reset;
        if (cmd_valid) w_state_nxt = (w_op == OP_POPACC) ? ST_BUSY : ST_RESP;
      end
      ST_BUSY: begin
        if (w_last) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_psum <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_rsp  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (w_op)
              OP_POPACC: begin
                r_x    <= w_xnor;
                r_psum <= '0;
                r_cnt  <= CNT_INIT;
              end
              OP_XNOR:  r_rsp <= w_xnor;
              OP_READ:  r_rsp <= 32'(r_acc);
              OP_CLEAR: begin
                r_rsp <= 32'(r_acc);
                r_acc <= '0;
              end
              default:  r_rsp <= '0;
            endcase
          end
        end
        ST_BUSY: begin
          r_psum <= w_psum_nxt;
          r_x    <= r_x >> BITS_PER_CYCLE;
          if (w_last) begin
            r_acc <= w_acc_new;
            r_rsp <= 32'(w_acc_new);
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_payload_outputs_0 = r_rsp;

endmodule

// File: tb/tb_cfu_xnor_seq.sv
module tb_cfu_xnor_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cv[3];
  logic        cr[3];
  logic [9:0]  fid_s[3];
  logic [31:0] a_s[3];
  logic [31:0] b_s[3];
  logic        rv[3];
  logic        rr[3];
  logic [31:0] ro[3];

  int checks = 0;
  int errors = 0;

`ifdef CFU_XNOR_SEQ_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  cfu_xnor_seq #(.BITS_PER_CYCLE(4), .ACC_WIDTH(32)) u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cv[0]), .cmd_ready(cr[0]),
    .cmd_payload_function_id(fid_s[0]), .cmd_payload_inputs_0(a_s[0]),
    .cmd_payload_inputs_1(b_s[0]), .rsp_valid(rv[0]), .rsp_ready(rr[0]),
    .rsp_payload_outputs_0(ro[0]));

  cfu_xnor_seq #(.BITS_PER_CYCLE(1), .ACC_WIDTH(6)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cv[1]), .cmd_ready(cr[1]),
    .cmd_payload_function_id(fid_s[1]), .cmd_payload_inputs_0(a_s[1]),
    .cmd_payload_inputs_1(b_s[1]), .rsp_valid(rv[1]), .rsp_ready(rr[1]),
    .rsp_payload_outputs_0(ro[1]));

  cfu_xnor_seq #(.BITS_PER_CYCLE(32), .ACC_WIDTH(6)) u_dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cv[2]), .cmd_ready(cr[2]),
    .cmd_payload_function_id(fid_s[2]), .cmd_payload_inputs_0(a_s[2]),
    .cmd_payload_inputs_1(b_s[2]), .rsp_valid(rv[2]), .rsp_ready(rr[2]),
    .rsp_payload_outputs_0(ro[2]));

  // ---------------- reference model ----------------
  longint unsigned acc_m[3];

  function automatic int bpc_of(int d);
    case (d)
      0: return 4;
      1: return 1;
      default: return 32;
    endcase
  endfunction

  function automatic int accw_of(int d);
    return (d == 0) ? 32 : 6;
  endfunction

  function automatic logic [31:0] model(int d, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint unsigned lim, s;
    logic [31:0] r;
    lim = (64'd1 << accw_of(d)) - 1;
    case (op)
      3'd0: r = ~(a ^ b);
      3'd1: begin
        s = acc_m[d] + longint'($countones(~(a ^ b)));
        if (SAT) acc_m[d] = (s > lim) ? lim : s;
        else     acc_m[d] = s & lim;
        r = 32'(acc_m[d]);
      end
      3'd2: r = 32'(acc_m[d]);
      3'd3: begin
        r = 32'(acc_m[d]);
        acc_m[d] = 0;
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(int d, logic [2:0] op);
    return (op == 3'd1) ? (32 / bpc_of(d) + 1) : 1;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL d%0d %s: got %0h expected %0h", d, name, act, exp);
    end
  endtask

  // Issue one command at a negedge, measure response latency in cycles after
  // the accepting edge, optionally back-pressure, then hand-shake.
  task automatic run_cmd(input int d, input logic [9:0] fid, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int hold, input bit rr_early,
                         input bit pend);
    int n;
    int lat;
    n = 0;
    while (!cr[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(d, "ready_before_cmd", 64'(cr[d]), 64'd1);
    if (!cr[d]) return;
    cv[d] = 1'b1; fid_s[d] = fid; a_s[d] = a; b_s[d] = b;
    rr[d] = rr_early;
    @(posedge clk);
    @(negedge clk);
    cv[d] = 1'b0;
    lat = 1;
    while (!rv[d] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk(d, "latency", 64'(lat), 64'(exp_lat));
    chk(d, "payload", 64'(ro[d]), 64'(exp_res));
    if (!rv[d]) return;
    for (int i = 0; i < hold; i++) begin
      if (pend) begin
        cv[d] = 1'b1; fid_s[d] = 10'(3); a_s[d] = $urandom; b_s[d] = $urandom;
      end
      @(negedge clk);
      chk(d, "hold_valid", 64'(rv[d]), 64'd1);
      chk(d, "hold_ready", 64'(cr[d]), 64'd0);
      chk(d, "hold_payload", 64'(ro[d]), 64'(exp_res));
    end
    cv[d] = 1'b0;
    rr[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr[d] = 1'b0;
    chk(d, "ready_after_rsp", 64'(cr[d]), 64'd1);
    chk(d, "valid_after_rsp", 64'(rv[d]), 64'd0);
  endtask

  task automatic run_model(input int d, input logic [9:0] fid, input logic [31:0] a,
                           input logic [31:0] b, input int hold, input bit rr_early,
                           input bit pend);
    logic [31:0] e;
    int l;
    l = lat_of(d, fid[2:0]);
    e = model(d, fid[2:0], a, b);
    run_cmd(d, fid, a, b, e, l, hold, rr_early, pend);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [9:0]  fid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] tmp;
    logic [31:0] small_exp[3];

    tbl[0]  = '{10'd0,   32'h000000FF, 32'h0000000F, 32'hFFFFFF0F, 1};
    tbl[1]  = '{10'd1,   32'h00000000, 32'h00000000, 32'd32,       9};
    tbl[2]  = '{10'd1,   32'h00000000, 32'h00000000, 32'd64,       9};
    tbl[3]  = '{10'd2,   32'h12345678, 32'h9ABCDEF0, 32'd64,       1};
    tbl[4]  = '{10'd3,   32'h0,        32'h0,        32'd64,       1};
    tbl[5]  = '{10'd2,   32'h0,        32'h0,        32'd0,        1};
    tbl[6]  = '{10'h3FD, 32'hDEADBEEF, 32'h01234567, 32'd0,        1};
    tbl[7]  = '{10'd1,   32'hAAAAAAAA, 32'hFFFFFFFF, 32'd16,       9};
    tbl[8]  = '{10'h3F9, 32'h0F0F0F0F, 32'h00000000, 32'd32,       9};
    tbl[9]  = '{10'd0,   32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1};
    tbl[10] = '{10'd2,   32'h0,        32'h0,        32'd32,       1};

    small_exp[0] = 32'd16;
    small_exp[1] = 32'd48;
    small_exp[2] = SAT ? 32'd63 : 32'd16;

    for (int d = 0; d < 3; d++) begin
      cv[d] = 1'b0; rr[d] = 1'b0; fid_s[d] = '0; a_s[d] = '0; b_s[d] = '0;
      acc_m[d] = 0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk(d, "reset_ready", 64'(cr[d]), 64'd0);
      chk(d, "reset_valid", 64'(rv[d]), 64'd0);
      chk(d, "reset_payload", 64'(ro[d]), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk(d, "ready_after_reset", 64'(cr[d]), 64'd1);

    // Table on the default build; the model tracks acc alongside.
    for (int i = 0; i < 11; i++) begin
      tmp = model(0, tbl[i].fid[2:0], tbl[i].a, tbl[i].b);
      run_cmd(0, tbl[i].fid, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, 0, 1'b0, 1'b0);
    end

    // Narrow accumulator builds: 1 and 32 bits per cycle, wrap/saturate.
    for (int d = 1; d < 3; d++) begin
      run_cmd(d, 10'd1, 32'hAAAAAAAA, 32'hFFFFFFFF, small_exp[0], lat_of(d, 3'd1), 0, 1'b0, 1'b0);
      run_cmd(d, 10'd1, 32'h0, 32'h0, small_exp[1], lat_of(d, 3'd1), 0, 1'b0, 1'b0);
      run_cmd(d, 10'd1, 32'h0, 32'h0, small_exp[2], lat_of(d, 3'd1), 0, 1'b1, 1'b0);
      tmp = model(d, 3'd1, 32'hAAAAAAAA, 32'hFFFFFFFF);
      tmp = model(d, 3'd1, 32'h0, 32'h0);
      tmp = model(d, 3'd1, 32'h0, 32'h0);
    end

    // Backpressure: 5 cycles held, a CLEAR offered meanwhile must be ignored.
    run_model(0, 10'd1, 32'h0, 32'h0, 5, 1'b0, 1'b1);
    run_model(0, 10'd2, 32'h0, 32'h0, 0, 1'b0, 1'b0);

    // Reset during BUSY, at cycle T+4 of a POPACC.
    while (!cr[0]) @(negedge clk);
    cv[0] = 1'b1; fid_s[0] = 10'd1; a_s[0] = 32'h0; b_s[0] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    cv[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk(0, "midreset_valid", 64'(rv[0]), 64'd0);
    chk(0, "midreset_ready", 64'(cr[0]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) acc_m[d] = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk(0, "post_reset_no_rsp", 64'(rv[0]), 64'd0);
    end
    chk(0, "post_reset_ready", 64'(cr[0]), 64'd1);
    run_cmd(0, 10'd2, 32'h0, 32'h0, 32'd0, 1, 0, 1'b0, 1'b0);

    // Randomized commands against the model.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 30; k++) begin
        logic [2:0]  op;
        logic [31:0] a, b;
        bit          rre;
        op  = (k % 3 == 0) ? 3'd1 : 3'($urandom_range(0, 7));
        a   = $urandom;
        b   = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
        rre = 1'($urandom_range(0, 1));
        run_model(d, {7'($urandom), op}, a, b, rre ? 0 : $urandom_range(0, 2), rre,
                  1'($urandom_range(0, 1)));
      end
      run_model(d, 10'd2, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
